// File: rtl/gps_bb_pkg.sv
// Shared definitions for the GPS baseband channel sequencing logic.
//   state_e    : code/epoch controller state encoding
//   CA_CHIPS   : C/A code length in chips
//   MS_PER_BIT : 1 ms code epochs per 20 ms navigation data bit
package gps_bb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SLEW = 2'd2
  } state_e;

  localparam int CA_CHIPS   = 1023;
  localparam int MS_PER_BIT = 20;

endpackage

// File: rtl/code_epoch_ctrl_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear.
// Ports:
//   clock  : system clock, rising edge
//   resetn : synchronous active-low reset
//   en     : advance by one this cycle
//   clr    : synchronous clear to 0, overrides en
//   q      : current count, always 0..MOD-1
//   wrap   : high in the cycle where an enabled advance takes q from MOD-1 to 0
module mod_counter #(
  parameter int MOD = 1023,
  parameter int W   = 10
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  // Terminal count is an equality compare, so non-power-of-two moduli wrap correctly.
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] q_q, q_d;

  assign wrap = en & ~clr & (q_q == LAST);

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = (q_q == LAST) ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/code_epoch_ctrl.sv
// Code-phase / data-epoch sequencer for one GPS baseband channel.
// Counts code-NCO chip ticks modulo CHIP_MOD, cascades into a modulo-EPOCH_MOD
// epoch counter, and swallows chip ticks on request to slew the code phase.
// Ports:
//   clock, resetn    : system clock, synchronous active-low reset
//   start, stop      : level controls; stop has priority
//   chip_tick        : one-cycle enable per code chip
//   slew_valid/ready : slew command handshake, slew_amount = ticks to swallow
//   chip_cnt         : chip index 0..CHIP_MOD-1
//   epoch_cnt        : epoch index 0..EPOCH_MOD-1
//   dump             : one-cycle pulse on chip counter wrap
//   bit_edge         : one-cycle pulse on epoch counter wrap (coincides with dump)
//   ctr_sclr         : synchronous clear for downstream accumulators/counters
//   busy             : high in RUN or SLEW
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | counters held at 0, ctr_sclr asserted, waiting for start
// RUN     | chip ticks advance the counters, slew commands accepted
// SLEW    | chip ticks swallowed until the slew remainder reaches 0
module code_epoch_ctrl
  import gps_bb_pkg::*;
#(
  parameter int CHIP_MOD  = CA_CHIPS,
  parameter int CHIP_W    = 10,
  parameter int EPOCH_MOD = MS_PER_BIT,
  parameter int EPOCH_W   = 5,
  parameter int SLEW_W    = 11
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               stop,
  input  logic               chip_tick,
  input  logic               slew_valid,
  input  logic [SLEW_W-1:0]  slew_amount,
  output logic               slew_ready,
  output logic [CHIP_W-1:0]  chip_cnt,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               dump,
  output logic               bit_edge,
  output logic               ctr_sclr,
  output logic               busy
);

  state_e            state_q, state_d;
  logic [SLEW_W-1:0] slew_rem_q, slew_rem_d;
  logic              dump_q, bit_edge_q, slew_ready_q, busy_q, ctr_sclr_q;

  logic chip_en, cnt_clr, chip_wrap, epoch_wrap;

  always_comb begin
    state_d    = state_q;
    slew_rem_d = slew_rem_q;
    chip_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          // A tick in the accept cycle still counts; swallowing starts next cycle.
          chip_en = chip_tick;
          if (slew_valid) begin
            state_d    = ST_SLEW;
            slew_rem_d = slew_amount;
          end
        end
      end
      ST_SLEW: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (slew_rem_q == '0) begin
          state_d = ST_RUN;
        end else if (chip_tick) begin
          slew_rem_d = slew_rem_q - SLEW_W'(1);
          // Leave on the last swallowed tick so RUN resumes right after it.
          if (slew_rem_q == SLEW_W'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) slew_rem_d = '0;
  end

  assign cnt_clr = (state_d == ST_IDLE);

  mod_counter #(.MOD(CHIP_MOD), .W(CHIP_W)) u_chip_ctr (
    .clock  (clock),
    .resetn (resetn),
    .en     (chip_en),
    .clr    (cnt_clr),
    .q      (chip_cnt),
    .wrap   (chip_wrap)
  );

  mod_counter #(.MOD(EPOCH_MOD), .W(EPOCH_W)) u_epoch_ctr (
    .clock  (clock),
    .resetn (resetn),
    .en     (chip_wrap),
    .clr    (cnt_clr),
    .q      (epoch_cnt),
    .wrap   (epoch_wrap)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      slew_rem_q   <= '0;
      dump_q       <= 1'b0;
      bit_edge_q   <= 1'b0;
      slew_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      ctr_sclr_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      slew_rem_q   <= slew_rem_d;
      dump_q       <= chip_wrap;
      bit_edge_q   <= epoch_wrap;
      slew_ready_q <= (state_d == ST_RUN);
      busy_q       <= (state_d != ST_IDLE);
      ctr_sclr_q   <= (state_d == ST_IDLE);
    end
  end

  assign dump       = dump_q;
  assign bit_edge   = bit_edge_q;
  assign slew_ready = slew_ready_q;
  assign busy       = busy_q;
  assign ctr_sclr   = ctr_sclr_q;

endmodule
